// File: rtl/alu_issue_ctrl.sv
// Two-stage valid/ready execute stage: decodes RV32I ops into ALU control, drives an external
// combinational ALU from stage-1 registers and captures result/branch outcome in stage 2.
// Optional ALU_ISSUE_STATS_EN adds saturating issue/taken counters.
module alu_issue_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_pc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_taken,
    output logic             out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_taken
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] CTRL_ADD = 4'b0000;
    localparam logic [3:0] CTRL_SUB = 4'b1000;
    localparam logic [3:0] CTRL_SLT = 4'b0010;

    typedef enum logic [1:0] {
        K_ALU    = 2'd0,
        K_JUMP   = 2'd1,
        K_BRANCH = 2'd2,
        K_ILL    = 2'd3
    } kind_e;

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;
    kind_e            dec_kind;

    logic             s1_valid;
    kind_e            s1_kind;
    logic [2:0]       s1_f3;
    logic             s2_free;
    logic             br_taken;
    logic [WIDTH-1:0] res_c;
    logic             taken_c;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    // Instruction decode into ALU op, operand selection and result kind
    always_comb begin
        dec_ctrl = CTRL_ADD;
        dec_a    = '0;
        dec_b    = '0;
        dec_kind = K_ILL;
        unique case (in_opcode)
            OPC_OP: begin
                dec_ctrl = {in_funct7b5, in_funct3};
                dec_a    = in_rs1;
                dec_b    = in_rs2;
                dec_kind = K_ALU;
            end
            OPC_OP_IMM: begin
                dec_ctrl = {in_funct7b5 & (in_funct3 == 3'b101), in_funct3};
                dec_a    = in_rs1;
                dec_b    = in_imm;
                dec_kind = K_ALU;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_a    = in_rs1;
                dec_b    = in_imm;
                dec_kind = K_ALU;
            end
            OPC_LUI: begin
                dec_b    = in_imm;
                dec_kind = K_ALU;
            end
            OPC_AUIPC: begin
                dec_a    = in_pc;
                dec_b    = in_imm;
                dec_kind = K_ALU;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a    = in_pc;
                dec_b    = WIDTH'(4);
                dec_kind = K_JUMP;
            end
            OPC_BRANCH: begin
                if (in_funct3[2:1] != 2'b01) begin
                    dec_ctrl = (in_funct3[2:1] == 2'b10) ? CTRL_SLT : CTRL_SUB;
                    dec_a    = in_rs1;
                    dec_b    = in_rs2;
                    dec_kind = K_BRANCH;
                end
            end
            default: ;
        endcase
    end

    // Stage 1: holds decoded op; ALU is driven only from these registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= CTRL_ADD;
            s1_kind  <= K_ALU;
            s1_f3    <= 3'b000;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                alu_a    <= dec_a;
                alu_b    <= dec_b;
                alu_ctrl <= dec_ctrl;
                s1_kind  <= dec_kind;
                s1_f3    <= in_funct3;
            end
        end
    end

    // Branch condition from ALU flags; funct3 bit 0 inverts the sense
    always_comb begin
        br_taken = 1'b0;
        unique case (s1_f3[2:1])
            2'b00:   br_taken = alu_zero;
            2'b10:   br_taken = alu_out[0];
            2'b11:   br_taken = alu_carry;
            default: br_taken = 1'b0;
        endcase
        br_taken = br_taken ^ s1_f3[0];
    end

    always_comb begin
        res_c   = '0;
        taken_c = 1'b0;
        unique case (s1_kind)
            K_ALU:    res_c = alu_out;
            K_JUMP: begin
                res_c   = alu_out;
                taken_c = 1'b1;
            end
            K_BRANCH: taken_c = br_taken;
            default:  ;
        endcase
    end

    // Stage 2: result register, refilled whenever empty or being drained
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= res_c;
                out_taken   <= taken_c;
                out_illegal <= (s1_kind == K_ILL);
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued <= 32'd0;
            stat_taken  <= 32'd0;
        end else if (out_valid && out_ready) begin
            if (stat_issued != 32'hFFFF_FFFF) stat_issued <= stat_issued + 32'd1;
            if (out_taken && (stat_taken != 32'hFFFF_FFFF)) stat_taken <= stat_taken + 32'd1;
        end
    end
`endif

endmodule
